// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, functs,
// ALU operations and FSM states.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

endpackage

// File: rtl/mips_multicycle_core_regfile.sv
// 32x32 register file: two combinational reads, one synchronous write,
// register 0 hard-wired to zero.
module mips_regfile (
    input  logic        clk_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk_i) begin
        if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : regs_q[ra2_i];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core sharing one req/ready memory port between
// instruction fetch and load/store.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic [31:0]           pc,
    output logic                  retire,
    output logic                  halted
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, pc4_q, pc4_d, ir_q, ir_d;
    logic [31:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [31:0] alu_q, alu_d, mdr_q, mdr_d;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic        legal;
    alu_op_e     alu_op;
    logic [31:0] opb, alu_y, rf_rd1, rf_rd2, rf_wd, addr_c;
    logic [4:0]  rf_wa;
    logic        rf_we, req_c, we_c, retire_c;
    logic        unused_ok;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign funct  = ir_q[5:0];

    always_comb begin
        legal  = 1'b0;
        alu_op = ALU_ADD;
        unique case (opcode)
            OP_RTYPE: begin
                legal = 1'b1;
                unique case (funct)
                    F_ADD:   alu_op = ALU_ADD;
                    F_SUB:   alu_op = ALU_SUB;
                    F_AND:   alu_op = ALU_AND;
                    F_OR:    alu_op = ALU_OR;
                    F_SLT:   alu_op = ALU_SLT;
                    default: legal = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign opb = (opcode == OP_RTYPE) ? b_q : imm_q;

    always_comb begin
        unique case (alu_op)
            ALU_SUB: alu_y = a_q - opb;
            ALU_AND: alu_y = a_q & opb;
            ALU_OR:  alu_y = a_q | opb;
            ALU_SLT: alu_y = {31'd0, $signed(a_q) < $signed(opb)};
            default: alu_y = a_q + opb;
        endcase
    end

    assign rf_wa = (opcode == OP_RTYPE) ? rd : rt;
    assign rf_wd = (opcode == OP_LW) ? mdr_q : alu_q;

    mips_regfile u_rf (
        .clk_i (clk),
        .ra1_i (rs),
        .ra2_i (rt),
        .rd1_o (rf_rd1),
        .rd2_o (rf_rd2),
        .we_i  (rf_we),
        .wa_i  (rf_wa),
        .wd_i  (rf_wd)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc4_d    = pc4_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        rf_we    = 1'b0;
        req_c    = 1'b0;
        we_c     = 1'b0;
        addr_c   = pc_q;
        retire_c = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc4_d   = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rf_rd1;
                b_d     = rf_rd2;
                imm_d   = {{16{ir_q[15]}}, ir_q[15:0]};
                state_d = legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                unique case (opcode)
                    OP_RTYPE, OP_ADDI: begin
                        alu_d   = alu_y;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_d   = alu_y;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        pc_d     = (a_q == b_q) ? pc4_q + {imm_q[29:0], 2'b00}
                                                : pc4_q;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_J: begin
                        pc_d     = {pc4_q[31:28], ir_q[25:0], 2'b00};
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                req_c  = 1'b1;
                we_c   = (opcode == OP_SW);
                addr_c = alu_q;
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        pc_d     = pc4_q;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                pc_d     = pc4_q;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            pc4_q   <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
        end
    end

    // Reset state is FETCH, so strobes are gated to stay low while held.
    assign mem_req   = reset & req_c;
    assign mem_we    = reset & we_c;
    assign mem_addr  = reset ? addr_c[MEM_ADDR_W-1:0] : '0;
    assign mem_wdata = reset ? b_q : '0;
    assign retire    = reset & retire_c;
    assign halted    = reset & (state_q == S_HALT);
    assign pc        = pc_q;

    assign unused_ok = ^{ir_q[10:6], addr_c};

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
Multi-cycle MIPS core: the successor to the single-cycle datapath. It replaces separate instruction/data memories with one shared memory port that uses a req/ready stall handshake. A state machine sequences each instruction over 3–5 cycles, and the core adds addi, j and halt-on-illegal-opcode. It sits between the top level and a unified memory (RAM or bus bridge) with arbitrary wait states.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
MEM_ADDR_W, 32, width of mem_addr; the PC and ALU address are truncated to the low MEM_ADDR_W bits (8..32).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low; core held in reset while reset=0
mem_req  out  1  memory request valid
mem_we  out  1  1=write (sw), 0=read (fetch/lw)
mem_addr  out  MEM_ADDR_W  byte address
mem_wdata  out  32  store data (rt value)
mem_rdata  in  32  read data, valid in the cycle mem_ready=1
mem_ready  in  1  transaction completes at the rising edge where mem_req=1 and mem_ready=1
pc  out  32  address of the current instruction
retire  out  1  one-cycle pulse when an instruction completes
halted  out  1  high once an illegal opcode has been decoded

Behaviour:
- Reset (async assert, sync release):
  - State=FETCH, pc=RESET_PC; IR, A, B and ALUOut registers = 0.
  - mem_req=0, mem_we=0, retire=0, halted=0.
  - Register file contents are not reset; the bench must write a register before reading it.
  - While in reset, outputs are combinational 0 regardless of clk.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc. Hold until mem_ready.
  - On mem_ready: IR<=mem_rdata, pc_plus4<=pc+4, go to DECODE.
- DECODE:
  - A<=rf[rs], B<=rf[rt], imm<=sign-extended IR[15:0].
  - Opcode not in {000000 with funct add/sub/and/or/slt, 100011 lw, 101011 sw, 000100 beq, 001000 addi, 000010 j}: go to HALT.
  - Unknown funct under opcode 0 is also illegal.
- EXEC:
  - R-type: ALUOut<=A op B, then WB.
  - addi: ALUOut<=A+imm, then WB.
  - lw/sw: ALUOut<=A+imm, then MEM.
  - beq: if A==B, pc<=pc_plus4+(imm<<2), else pc<=pc_plus4; retire, then FETCH.
  - j: pc<={pc_plus4[31:28],IR[25:0],2'b00}; retire, then FETCH.
- MEM:
  - mem_req=1, mem_addr=ALUOut; mem_we=1 for sw with mem_wdata=B.
  - Hold until mem_ready.
  - lw: MDR<=mem_rdata, then WB.
  - sw: pc<=pc_plus4, retire, then FETCH.
- WB:
  - Write rd (R-type), rt (addi) or rt with MDR (lw).
  - pc<=pc_plus4, retire, then FETCH.
- HALT: absorbing state until reset. halted=1, mem_req=0, pc frozen at the offending instruction, no retire.
- Cycle counts with mem_ready tied high: R-type/addi/sw 4, lw 5, beq/j 3. Each wait cycle adds one.
- Request stability: mem_addr, mem_we and mem_wdata are stable while mem_req=1 and mem_ready=0. mem_req deasserts in the cycle after completion unless the next state also requests.
- Arithmetic:
  - 32-bit two's complement; add, sub and addi wrap silently (no overflow trap).
  - slt is signed; result is 32'd1 or 32'd0.
  - Branch offset and PC arithmetic wrap modulo 2^32.
- Register $0:
  - Writes to $0 are discarded; reads of $0 return 0.
  - A register written in WB is visible to the next instruction's DECODE.
- Misalignment: low address bits are passed unchanged; there is no alignment trap.
- Reset during a pending memory request: mem_req drops immediately. Memory must tolerate the abandoned transaction; no register or PC update occurs.

Decomposition:
- Package mips_pkg:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - Funct constants: F_ADD, F_SUB, F_AND, F_OR, F_SLT.
  - 3-bit ALU-op encoding.
  - State encoding (FETCH..HALT).
- One sub-module, mips_regfile: 32x32, two combinational read ports, one synchronous write port with write enable, $0 hard-wired to zero.
- The ALU and FSM stay in the core.

Test Plan:
- Program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,0($0); zero-wait memory -> mem[0]=12, retire pulses at cycles 4, 8, 12, 16 after reset release.
- lw $4,0($0) with mem_ready low for 3 cycles in FETCH and 2 in MEM -> instruction takes 10 cycles; mem_addr/mem_req stable during waits; $4=12.
- beq $1,$1,-1 at pc=0x10 -> pc returns to 0x10, 3 cycles per iteration. Then beq $1,$2,+2 (not equal) -> pc=0x14.
- j 0x0000040 at pc=0x20 -> next fetch address 0x100; addi $0,$0,9 -> $0 still reads 0; slt with $1=-1, $2=1 -> result 1.
- Opcode 6'b111111 fetched at 0x08 -> halted=1, mem_req=0 forever, pc=0x08, no retire. Pull reset low mid-FETCH with mem_req=1 -> mem_req=0 immediately; after release, fetch from RESET_PC.
